// File: rtl/nn_pkg.sv
// Shared types and default dimensions for the inference layer sequencer.
package nn_pkg;

    localparam int LENGTH = 28;
    localparam int WIDTH  = 28;
    localparam int N_OUT  = 10;
    localparam int PIX_W  = 8;
    localparam int W_W    = 8;
    localparam int ACC_W  = 26;

    typedef logic [PIX_W-1:0]        pix_t;
    typedef logic signed [W_W-1:0]   weight_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, BIAS, CMP, DONE} state_t;

endpackage

// File: rtl/nn_mac.sv
// Unsigned-pixel x signed-weight multiply-accumulate with clear, enable and a
// bias path that adds the sign-extended weight operand directly.
module nn_mac #(
    parameter int PIX_W = 8,
    parameter int W_W   = 8,
    parameter int ACC_W = 26
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic                    bias_i,
    input  logic [PIX_W-1:0]        pix_i,
    input  logic signed [W_W-1:0]   w_i,
    output logic signed [ACC_W-1:0] acc_o
);

    localparam int PROD_W = PIX_W + W_W + 1;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  addend;
    logic signed [ACC_W-1:0]  acc_q, acc_d;

    always_comb begin
        prod   = PROD_W'($signed({1'b0, pix_i})) * PROD_W'(w_i);
        addend = bias_i ? ACC_W'(w_i) : ACC_W'(prod);
        acc_d  = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + addend;  // wraps modulo 2^ACC_W
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/nn_infer_sequencer.sv
// Fully-connected layer sequencer: walks pixel/weight addresses, accumulates per
// neuron and reports the argmax class. Define NN_BIAS_EN to add per-neuron biases.
module nn_infer_sequencer #(
    parameter int  N_PIXELS = nn_pkg::LENGTH * nn_pkg::WIDTH,
    parameter int  N_OUT    = nn_pkg::N_OUT,
    parameter int  PIX_W    = nn_pkg::PIX_W,
    parameter int  W_W      = nn_pkg::W_W,
    parameter int  ACC_W    = nn_pkg::ACC_W,
    localparam int PA_W     = $clog2(N_PIXELS),
    localparam int WA_W     = $clog2(N_OUT * N_PIXELS + N_OUT)
) (
    input  logic                  pi_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  img_ready,
    output logic [PA_W-1:0]       pix_addr,
    input  logic [PIX_W-1:0]      pix_rd_data,
    output logic [WA_W-1:0]       w_addr,
    input  logic signed [W_W-1:0] w_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            class_out,
    output logic                  class_valid
);

    import nn_pkg::*;

    state_t                  state_q, state_d;
    logic [3:0]              j_q, j_d;
    logic [3:0]              best_idx_q, best_idx_d;
    logic [3:0]              class_out_q, class_out_d;
    logic [PA_W-1:0]         pix_addr_q, pix_addr_d;
    logic [WA_W-1:0]         w_addr_q, w_addr_d;
    logic signed [ACC_W-1:0] best_q, best_d;
    logic signed [ACC_W-1:0] acc;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    class_valid_q, class_valid_d;
    logic                    mac_clr, mac_en, mac_bias;
    logic                    last_pix, last_neuron;
`ifdef NN_BIAS_EN
    logic                    bias_ph_q, bias_ph_d;
`endif

    assign last_pix    = (pix_addr_q == PA_W'(N_PIXELS - 1));
    assign last_neuron = (j_q == 4'(N_OUT - 1));

    nn_mac #(
        .PIX_W (PIX_W),
        .W_W   (W_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk_i   (pi_clk),
        .rst_n_i (rst_n),
        .clr_i   (mac_clr),
        .en_i    (mac_en),
        .bias_i  (mac_bias),
        .pix_i   (pix_rd_data),
        .w_i     (w_rd_data),
        .acc_o   (acc)
    );

    always_ff @(posedge pi_clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            j_q           <= '0;
            best_idx_q    <= '0;
            class_out_q   <= '0;
            pix_addr_q    <= '0;
            w_addr_q      <= '0;
            best_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            class_valid_q <= 1'b0;
`ifdef NN_BIAS_EN
            bias_ph_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            j_q           <= j_d;
            best_idx_q    <= best_idx_d;
            class_out_q   <= class_out_d;
            pix_addr_q    <= pix_addr_d;
            w_addr_q      <= w_addr_d;
            best_q        <= best_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            class_valid_q <= class_valid_d;
`ifdef NN_BIAS_EN
            bias_ph_q     <= bias_ph_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start && img_ready) state_d = LOAD;
            LOAD:    if (last_pix) state_d = DRAIN;
`ifdef NN_BIAS_EN
            DRAIN:   state_d = BIAS;
            BIAS:    if (bias_ph_q) state_d = CMP;
`else
            DRAIN:   state_d = CMP;
            BIAS:    state_d = IDLE;
`endif
            CMP:     state_d = last_neuron ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        j_d           = j_q;
        best_idx_d    = best_idx_q;
        class_out_d   = class_out_q;
        pix_addr_d    = pix_addr_q;
        w_addr_d      = w_addr_q;
        best_d        = best_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        class_valid_d = class_valid_q;
        mac_clr       = 1'b0;
        mac_en        = 1'b0;
        mac_bias      = 1'b0;
`ifdef NN_BIAS_EN
        bias_ph_d     = bias_ph_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && img_ready) begin
                    j_d        = '0;
                    pix_addr_d = '0;
                    w_addr_d   = '0;
                    mac_clr    = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            LOAD: begin
                // read data lags the address by one cycle, so k=0 has nothing yet
                mac_en = (pix_addr_q != '0);
                if (!last_pix) begin
                    pix_addr_d = pix_addr_q + PA_W'(1);
                    w_addr_d   = w_addr_q + WA_W'(1);
                end
            end
            DRAIN: begin
                mac_en = 1'b1;
`ifdef NN_BIAS_EN
                w_addr_d  = WA_W'(N_OUT * N_PIXELS + int'(j_q));
                bias_ph_d = 1'b0;
`endif
            end
            BIAS: begin
`ifdef NN_BIAS_EN
                bias_ph_d = 1'b1;
                mac_en    = bias_ph_q;
                mac_bias  = bias_ph_q;
`endif
            end
            CMP: begin
                // strict compare keeps the lowest index on ties
                if (j_q == '0 || acc > best_q) begin
                    best_d     = acc;
                    best_idx_d = j_q;
                end
                if (!last_neuron) begin
                    j_d        = j_q + 4'd1;
                    pix_addr_d = '0;
                    w_addr_d   = WA_W'((int'(j_q) + 1) * N_PIXELS);
                    mac_clr    = 1'b1;
                end
            end
            DONE: begin
                class_out_d   = best_idx_q;
                class_valid_d = 1'b1;
                done_d        = 1'b1;
                busy_d        = 1'b0;
            end
            default: ;
        endcase
    end

    assign pix_addr    = pix_addr_q;
    assign w_addr      = w_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign class_out   = class_out_q;
    assign class_valid = class_valid_q;

endmodule

// File: tb/tb_nn_infer_sequencer.sv
// Self-checking bench: a 4-pixel/3-neuron instance for vectors and corner cases,
// plus a default-size instance for the full-range accumulation cases.
module tb_nn_infer_sequencer;

`ifdef NN_BIAS_EN
    localparam int PER = 4;
`else
    localparam int PER = 2;
`endif
    localparam int LAT_S = 3 * (4 + PER) + 1;
    localparam int LAT_B = 10 * (784 + PER) + 1;

    typedef struct {
        int cls;
        int cyc;
    } exp_t;

    typedef struct {
        int p;
        int w0;
        int w1;
        int w2;
        int b2;
        int exp_nb;
        int exp_b;
    } vec_t;

    logic clk, rst_n;
    logic start_s, ready_s, start_b, ready_b;

    logic [1:0]        pix_addr_s;
    logic [7:0]        pix_rd_s;
    logic [3:0]        w_addr_s;
    logic signed [7:0] w_rd_s;
    logic              busy_s, done_s, cv_s;
    logic [3:0]        class_s;

    logic [9:0]        pix_addr_b;
    logic [7:0]        pix_rd_b;
    logic [12:0]       w_addr_b;
    logic signed [7:0] w_rd_b;
    logic              busy_b, done_b, cv_b;
    logic [3:0]        class_b;

    logic [7:0] pix_mem_s [4];
    logic [7:0] w_mem_s   [16];
    logic [7:0] pix_mem_b [1024];
    logic [7:0] w_mem_b   [8192];

    exp_t sb_s[$];
    exp_t sb_b[$];
    vec_t vecs[6];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int bias_hits = 0;

    nn_infer_sequencer #(.N_PIXELS(4), .N_OUT(3)) dut_s (
        .pi_clk(clk), .rst_n(rst_n), .start(start_s), .img_ready(ready_s),
        .pix_addr(pix_addr_s), .pix_rd_data(pix_rd_s),
        .w_addr(w_addr_s), .w_rd_data(w_rd_s),
        .busy(busy_s), .done(done_s), .class_out(class_s), .class_valid(cv_s)
    );

    nn_infer_sequencer dut_b (
        .pi_clk(clk), .rst_n(rst_n), .start(start_b), .img_ready(ready_b),
        .pix_addr(pix_addr_b), .pix_rd_data(pix_rd_b),
        .w_addr(w_addr_b), .w_rd_data(w_rd_b),
        .busy(busy_b), .done(done_b), .class_out(class_b), .class_valid(cv_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        pix_rd_s <= pix_mem_s[pix_addr_s];
        w_rd_s   <= w_mem_s[w_addr_s];
        pix_rd_b <= pix_mem_b[pix_addr_b];
        w_rd_b   <= w_mem_b[w_addr_b];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done_s) begin
            if (sb_s.size() == 0) begin
                check("s_unexpected_done", 1, 0);
            end else begin
                e = sb_s.pop_front();
                $display("txn small class=%0d cycle=%0d", class_s, cyc);
                check("s_class_out", int'(class_s), e.cls);
                check("s_done_cycle", cyc, e.cyc);
                check("s_class_valid", int'(cv_s), 1);
                check("s_busy_at_done", int'(busy_s), 0);
            end
        end
        if (done_b) begin
            if (sb_b.size() == 0) begin
                check("b_unexpected_done", 1, 0);
            end else begin
                e = sb_b.pop_front();
                $display("txn big class=%0d cycle=%0d", class_b, cyc);
                check("b_class_out", int'(class_b), e.cls);
                check("b_done_cycle", cyc, e.cyc);
                check("b_class_valid", int'(cv_b), 1);
            end
        end
`ifndef NN_BIAS_EN
        if (w_addr_s >= 4'd12 || w_addr_b >= 13'd7840) bias_hits++;
`endif
    end

    task automatic kick(input bit big, input int cls);
        @(negedge clk);
        if (big) begin
            start_b = 1'b1;
            sb_b.push_back('{cls, cyc + 1 + LAT_B});
        end else begin
            start_s = 1'b1;
            sb_s.push_back('{cls, cyc + 1 + LAT_S});
        end
        @(negedge clk);
        start_s = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_idle(input bit big, input int bound);
        int n;
        n = 0;
        while ((big ? (sb_b.size() != 0 || busy_b) : (sb_s.size() != 0 || busy_s)) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: no done after %0d cycles, required within %0d", n, bound);
            if (big) sb_b.delete(); else sb_s.delete();
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int k = 0; k < 4; k++) begin
            pix_mem_s[k]  = 8'(v.p);
            w_mem_s[k]     = 8'(v.w0);
            w_mem_s[4 + k] = 8'(v.w1);
            w_mem_s[8 + k] = 8'(v.w2);
        end
        w_mem_s[12] = 8'd0;
        w_mem_s[13] = 8'd0;
        w_mem_s[14] = 8'(v.b2);
        w_mem_s[15] = 8'd0;
    endtask

    function automatic int model_class_s();
        int best, bi, s;
        best = 0;
        bi = 0;
        for (int j = 0; j < 3; j++) begin
            s = 0;
            for (int k = 0; k < 4; k++)
                s += int'(pix_mem_s[k]) * int'($signed(w_mem_s[j * 4 + k]));
`ifdef NN_BIAS_EN
            s += int'($signed(w_mem_s[12 + j]));
`endif
            if (j == 0 || s > best) begin
                best = s;
                bi = j;
            end
        end
        return bi;
    endfunction

    function automatic int vec_exp(input vec_t v);
`ifdef NN_BIAS_EN
        return v.exp_b;
`else
        return v.exp_nb;
`endif
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        //          p    w0    w1    w2   b2  nb  b
        vecs[0] = '{1,    1,    2,   -1,  20,  1, 2};
        vecs[1] = '{1,    2,    1,    2,   0,  0, 0};
        vecs[2] = '{1,   -1,   -1,   -2,   0,  0, 0};
        vecs[3] = '{1,   -3,   -1,   -2,  20,  1, 2};
        vecs[4] = '{0,    5,    7,    9,  -1,  0, 0};
        vecs[5] = '{255, -128, 127, 127,  -1,  1, 1};

        rst_n = 1'b0;
        start_s = 1'b0; ready_s = 1'b1;
        start_b = 1'b0; ready_b = 1'b1;
        for (int i = 0; i < 1024; i++) pix_mem_b[i] = 8'd255;
        for (int i = 0; i < 8192; i++) w_mem_b[i] = (i < 7840) ? 8'h80 : 8'h00;
        load_vec(vecs[0]);

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy_s), 0);
        check("rst_done", int'(done_s), 0);
        check("rst_class_valid", int'(cv_s), 0);
        check("rst_class_out", int'(class_s), 0);
        check("rst_pix_addr", int'(pix_addr_s), 0);
        check("rst_w_addr", int'(w_addr_s), 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            load_vec(vecs[i]);
            kick(1'b0, vec_exp(vecs[i]));
            check("run_busy", int'(busy_s), 1);
            wait_idle(1'b0, LAT_S + 20);
        end

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4; k++) pix_mem_s[k] = 8'($urandom_range(255));
            for (int a = 0; a < 16; a++) w_mem_s[a] = 8'($urandom_range(255));
            kick(1'b0, model_class_s());
            wait_idle(1'b0, LAT_S + 20);
        end

        // start ignored without img_ready
        load_vec(vecs[0]);
        ready_s = 1'b0;
        @(negedge clk);
        start_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("noready_busy", int'(busy_s), 0);
        end
        start_s = 1'b0;
        ready_s = 1'b1;

        // second start pulse mid-run is dropped
        kick(1'b0, vec_exp(vecs[0]));
        repeat (4) @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        wait_idle(1'b0, LAT_S + 20);
        repeat (LAT_S + 5) @(negedge clk);

        // start held high re-triggers right after DONE
        @(negedge clk);
        start_s = 1'b1;
        c0 = cyc;
        sb_s.push_back('{vec_exp(vecs[0]), c0 + 1 + LAT_S});
        sb_s.push_back('{vec_exp(vecs[0]), c0 + 2 + 2 * LAT_S});
        repeat (LAT_S + 2) @(negedge clk);
        start_s = 1'b0;
        wait_idle(1'b0, LAT_S + 20);

        // reset mid-run aborts without done
        kick(1'b0, vec_exp(vecs[0]));
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy_s), 0);
        check("abort_class_valid", int'(cv_s), 0);
        check("abort_done", int'(done_s), 0);
        check("abort_class_out", int'(class_s), 0);
        sb_s.delete();
        rst_n = 1'b1;
        repeat (LAT_S) @(negedge clk);
        check("abort_still_idle", int'(busy_s), 0);
        kick(1'b0, vec_exp(vecs[0]));
        wait_idle(1'b0, LAT_S + 20);

        // full-size image: all equal scores, then one positive neuron
        kick(1'b1, 0);
        wait_idle(1'b1, LAT_B + 20);
        for (int k = 0; k < 784; k++) w_mem_b[3 * 784 + k] = 8'h7f;
        kick(1'b1, 3);
        wait_idle(1'b1, LAT_B + 20);

`ifndef NN_BIAS_EN
        check("no_bias_addr", bias_hits, 0);
`endif
        check("final_class_valid_b", int'(cv_b), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
